// File: rtl/float_pkg.sv
// Shared definitions for the minifloat arithmetic blocks: FSM states,
// guard/round/sticky width and exponent helper constants.
package float_pkg;

  // Guard, round and sticky bits carried below the mantissa lsb
  localparam int GRS_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  // Exponent bias for an exp_w-bit exponent field
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Largest encodable exponent (all-ones is an ordinary finite exponent)
  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised significand with G/R/S bits.
// Produces the stored {exp, man} fields and saturates on exponent overflow.
module fp_round_rne
  import float_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3
) (
  input  logic [MAN_W:0]   i_sig,      // {hidden, man}, hidden bit is 1
  input  logic             i_g,
  input  logic             i_r,
  input  logic             i_s,
  input  logic [EXP_W:0]   i_exp,      // one extra bit to see overflow
  output logic [EXP_W-1:0] o_exp,
  output logic [MAN_W-1:0] o_man,
  output logic             o_overflow
);

  localparam logic [EXP_W+1:0] EXP_LIM = (EXP_W + 2)'(exp_max(EXP_W));

  logic               w_inc;
  logic [MAN_W+1:0]   w_sig_rnd;
  logic               w_carry;
  logic [EXP_W+1:0]   w_exp_rnd;
  logic [MAN_W-1:0]   w_man_rnd;

  // Round up above half, and on an exact half only when the lsb is odd
  assign w_inc     = i_g & (i_r | i_s | i_sig[0]);
  assign w_sig_rnd = {1'b0, i_sig} + (MAN_W + 2)'(w_inc);

  // Rounding 1.111..1 up gives 10.000..0: bump exponent, mantissa becomes 0
  assign w_carry   = w_sig_rnd[MAN_W+1];
  assign w_exp_rnd = {1'b0, i_exp} + (EXP_W + 2)'(w_carry);
  assign w_man_rnd = w_carry ? '0 : w_sig_rnd[MAN_W-1:0];

  assign o_overflow = (w_exp_rnd > EXP_LIM);
  assign o_exp      = o_overflow ? '1 : w_exp_rnd[EXP_W-1:0];
  assign o_man      = o_overflow ? '1 : w_man_rnd;

endmodule

// File: rtl/float_adder_param.sv
// Multi-cycle minifloat adder/subtractor (default E4M3) with valid/ready
// handshakes, RNE rounding, flush-to-zero and saturation. One operation in
// flight; align, add, normalise and round each take their own cycle(s).
module float_adder_param
  import float_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         overflow,
  output logic         underflow
);

  localparam int SIG_W = MAN_W + 1;        // significand incl. hidden bit
  localparam int EXT_W = SIG_W + GRS_W;    // significand plus G/R/S
  localparam int SUM_W = EXT_W + 1;        // plus carry-out
  localparam logic [31:0]  SHIFT_LIM = 32'(MAN_W + GRS_W);
  localparam logic [EXP_W:0] EXP_ONE = 1;

  state_t             r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;                 // sign already holds b.sign ^ sub
  logic [EXT_W-1:0]   r_sig_x;
  logic [EXT_W-1:0]   r_sig_y;
  logic [EXP_W:0]     r_exp;
  logic               r_sign;
  logic               r_eff_sub;
  logic [SUM_W-1:0]   r_sum;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [W-1:0]       r_y;
  logic               r_overflow;
  logic               r_underflow;

  // Operand swap so that X has the larger {exp, man} magnitude
  logic               w_swap;
  logic [EXP_W-1:0]   w_x_exp, w_y_exp;
  logic [MAN_W-1:0]   w_x_man, w_y_man;
  logic               w_x_sign;
  logic [SIG_W-1:0]   w_x_sig, w_y_sig;
  logic [EXP_W-1:0]   w_d;
  logic [31:0]        w_d_ext;
  logic [2*EXT_W-1:0] w_y_wide;
  logic [EXT_W-1:0]   w_y_aligned;
  logic [SUM_W-1:0]   w_sum;

  assign w_swap   = (r_b[W-2:0] > r_a[W-2:0]);
  assign w_x_exp  = w_swap ? r_b[W-2 -: EXP_W] : r_a[W-2 -: EXP_W];
  assign w_y_exp  = w_swap ? r_a[W-2 -: EXP_W] : r_b[W-2 -: EXP_W];
  assign w_x_man  = w_swap ? r_b[MAN_W-1:0]    : r_a[MAN_W-1:0];
  assign w_y_man  = w_swap ? r_a[MAN_W-1:0]    : r_b[MAN_W-1:0];
  assign w_x_sign = w_swap ? r_b[W-1]          : r_a[W-1];

  // Exponent 0 encodes zero regardless of mantissa
  assign w_x_sig  = (w_x_exp != '0) ? {1'b1, w_x_man} : '0;
  assign w_y_sig  = (w_y_exp != '0) ? {1'b1, w_y_man} : '0;

  // Alignment: the lower half of the wide shift holds everything past S
  assign w_d      = w_x_exp - w_y_exp;
  assign w_d_ext  = 32'(w_d);
  assign w_y_wide = {w_y_sig, {GRS_W{1'b0}}, {EXT_W{1'b0}}} >> w_d;
  assign w_y_aligned = (w_d_ext >= SHIFT_LIM)
    ? {{(EXT_W-1){1'b0}}, |w_y_sig}
    : {w_y_wide[2*EXT_W-1:EXT_W+1], w_y_wide[EXT_W] | (|w_y_wide[EXT_W-1:0])};

  // X >= Y in magnitude, so the difference is never negative
  assign w_sum = r_eff_sub ? ({1'b0, r_sig_x} - {1'b0, r_sig_y})
                           : ({1'b0, r_sig_x} + {1'b0, r_sig_y});

  logic [EXP_W-1:0] w_rnd_exp;
  logic [MAN_W-1:0] w_rnd_man;
  logic             w_rnd_ovf;

  fp_round_rne #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .i_sig      (r_sum[EXT_W-1:GRS_W]),
    .i_g        (r_sum[2]),
    .i_r        (r_sum[1]),
    .i_s        (r_sum[0]),
    .i_exp      (r_exp),
    .o_exp      (w_rnd_exp),
    .o_man      (w_rnd_man),
    .o_overflow (w_rnd_ovf)
  );

  // Operation sequencer; datapath registers and all outputs are registered here
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sig_x     <= '0;
      r_sig_y     <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_eff_sub   <= 1'b0;
      r_sum       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= {b[W-1] ^ sub, b[W-2:0]};
            r_in_ready <= 1'b0;
            r_state    <= ALIGN;
          end
        end
        ALIGN: begin
          r_sig_x   <= {w_x_sig, {GRS_W{1'b0}}};
          r_sig_y   <= w_y_aligned;
          r_exp     <= {1'b0, w_x_exp};
          r_sign    <= w_x_sign;
          r_eff_sub <= r_a[W-1] ^ r_b[W-1];
          r_state   <= ADD;
        end
        ADD: begin
          r_sum   <= w_sum;
          r_state <= NORM;
        end
        NORM: begin
          // An exact-zero sum is recognised on the registered sum and yields +0
          if (r_sum == '0) begin
            r_y         <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_sum[SUM_W-1]) begin
            r_sum <= {1'b0, r_sum[SUM_W-1:2], r_sum[1] | r_sum[0]};
            r_exp <= r_exp + EXP_ONE;
          end else if (!r_sum[EXT_W-1]) begin
            if (r_exp <= EXP_ONE) begin
              r_y         <= '0;
              r_overflow  <= 1'b0;
              r_underflow <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_sum <= {r_sum[SUM_W-2:0], 1'b0};
              r_exp <= r_exp - EXP_ONE;
            end
          end else begin
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_y         <= {r_sign, w_rnd_exp, w_rnd_man};
          r_overflow  <= w_rnd_ovf;
          r_underflow <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_float_adder_param.sv
// Directed-vector bench for float_adder_param in its E4M3 default.
module tb_float_adder_param;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;

  float_adder_param dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait (bounded) for out_valid, check, hand off
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tsub, input logic [7:0] ey, input logic eo,
                        input logic eu, input int elat);
    int lat;
    lat = 0;
    a = ta; b = tb_v; sub = tsub; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, in_ready, 0);
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    $display("op %s a=%h b=%h sub=%b y=%h ovf=%b unf=%b lat=%0d",
             tag, ta, tb_v, tsub, y, overflow, underflow, lat);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_y"}, y, ey);
    check({tag, "_ovf"}, overflow, eo);
    check({tag, "_unf"}, underflow, eu);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({tag, "_vdrop"}, out_valid, 0);
    check({tag, "_rdy"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    int seen_valid;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("one_plus_one",  8'h38, 8'h38, 1'b0, 8'h40, 1'b0, 1'b0, 5);
    run_op("x_minus_x",     8'h38, 8'h38, 1'b1, 8'h00, 1'b0, 1'b0, 3);
    run_op("negx_plus_x",   8'hB8, 8'h38, 1'b0, 8'h00, 1'b0, 1'b0, 3);
    run_op("cancel3",       8'h38, 8'h36, 1'b1, 8'h20, 1'b0, 1'b0, 7);
    run_op("tie_even",      8'h38, 8'h18, 1'b0, 8'h38, 1'b0, 1'b0, 4);
    run_op("tie_odd",       8'h39, 8'h18, 1'b0, 8'h3A, 1'b0, 1'b0, 4);
    run_op("exact",         8'h3C, 8'h28, 1'b0, 8'h3E, 1'b0, 1'b0, 4);
    run_op("sign_larger",   8'h28, 8'hB8, 1'b0, 8'hB4, 1'b0, 1'b0, 5);
    run_op("saturate",      8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b1, 1'b0, 5);
    run_op("flush",         8'h09, 8'h08, 1'b1, 8'h00, 1'b0, 1'b1, 3);
    run_op("b_zero",        8'h38, 8'h00, 1'b0, 8'h38, 1'b0, 1'b0, 4);
    run_op("a_zero",        8'h00, 8'hB8, 1'b0, 8'hB8, 1'b0, 1'b0, 4);

    // Backpressure: result held stable, busy, and new operands ignored
    a = 8'h3C; b = 8'h28; sub = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check("hold_start_valid", out_valid, 1);
    a = 8'h7F; b = 8'h7F; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      $display("hold cycle %0d y=%h out_valid=%b in_ready=%b", i, y, out_valid, in_ready);
      check("hold_valid", out_valid, 1);
      check("hold_y", y, 8'h3E);
      check("hold_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen_valid++;
    end
    check("hold_ignored", seen_valid, 0);

    // Reset mid-normalisation abandons the operation
    a = 8'h38; b = 8'h36; sub = 1'b1; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    $display("reset mid-op out_valid=%b in_ready=%b", out_valid, in_ready);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_rdy", in_ready, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen_valid++;
    end
    check("rst_mid_no_emit", seen_valid, 0);

    run_op("after_reset",   8'h38, 8'h38, 1'b0, 8'h40, 1'b0, 1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_adder_param.md
Name: float_adder_param

Overview:
- Parametrised, multi-cycle floating-point adder/subtractor for small minifloat formats. Default is E4M3; also targets E5M2 and wider formats.
- Successor to the fixed 8-bit adder. Adds:
  - valid/ready handshakes on both sides
  - an add/subtract mode input
  - correct sign of the larger magnitude
  - round-to-nearest-even using guard, round and sticky bits
  - flush-to-zero and saturation on overflow
- Sits between operand registers and the accumulator in the datapath. Handles one operation at a time.

Parameters:
- EXP_W, 4, exponent field width (2..8)
- MAN_W, 3, stored mantissa field width (1..10); hidden bit is implicit
- W, 1+EXP_W+MAN_W, total word width (derived; do not override)

Ports:
- clock  input  1  clock; all state updates on posedge
- reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands a, b and sub are presented
- in_ready  output  1  block is idle and accepts operands
- a  input  W  operand A {sign, exp, man}
- b  input  W  operand B
- sub  input  1  1: compute a-b (invert the sign of b); 0: a+b
- out_valid  output  1  y is valid
- out_ready  input  1  consumer takes y
- y  output  W  result
- overflow  output  1  result saturated; valid with out_valid
- underflow  output  1  nonzero result flushed to zero; valid with out_valid

Behaviour:
- Reset values: in_ready=1, out_valid=0, y=0, overflow=0, underflow=0, state=IDLE. A reset mid-operation abandons the operation; nothing is emitted.
- Encoding:
  - Exponent field 0 means the value is zero; the mantissa is ignored (no subnormals).
  - No Inf or NaN: the all-ones exponent is an ordinary finite exponent.
  - Bias is 2^(EXP_W-1)-1.
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1. On in_valid, latch a, b and sub (effective b sign = b.sign^sub) and go to ALIGN.
- ALIGN (1 cycle):
  - Swap the operands so that X has the larger {exp, man} magnitude.
  - Right-shift Y's significand {1, man} by exp difference d, keeping 3 extra bits (G, R, S). S is the OR of all bits shifted past R.
  - If d ≥ MAN_W+3, Y becomes sticky only.
  - A zero operand contributes a significand of 0.
- ADD (1 cycle):
  - Same effective signs: add. Different signs: subtract X−Y; the result is never negative.
  - Result sign = sign of X.
  - Exact zero (including 0±0 and x−x): y=+0 and go to DONE (a-b with a=b gives +0).
- NORM (one step per cycle):
  - On carry-out: shift right by 1 (the shifted-out bit ORs into S) and increment the exponent. One cycle.
  - Otherwise, while the hidden bit is 0: shift left by 1 and decrement the exponent, one bit per cycle.
  - If the exponent reaches 0 while normalising: underflow=1, y=+0 (sign forced to 0), go to DONE.
  - Leave NORM when the hidden bit is 1.
- ROUND (1 cycle):
  - RNE: increment when G & (R|S|lsb).
  - Mantissa overflow from rounding renormalises: exponent+1, mantissa=0.
  - If the exponent exceeds all-ones: overflow=1, y={sign, all-ones exp, all-ones man}.
- DONE:
  - out_valid=1. y, overflow and underflow are held stable while out_ready=0.
  - When out_valid & out_ready: go to IDLE; in_ready rises the next cycle. No back-to-back acceptance.
- Latency, from the in_valid accept edge to out_valid: 4 + (NORM shift cycles). Minimum 4; maximum 4+MAN_W+1. The exact-zero path takes 3.
- in_ready=0 in every state other than IDLE. Inputs are ignored while busy.

Decomposition:
- Package float_pkg holds:
  - the state enum
  - helper constants BIAS(EXP_W) and EXP_MAX(EXP_W)
  - GRS width = 3
- One sub-module is natural: fp_round_rne (combinational). Inputs are the normalised significand, G, R, S and the exponent. Outputs are the rounded {exp, man} and the overflow flag. It can be reused by a future multiplier.

Test Plan (E4M3 defaults; hex values are W-bit words):
- a=0x38 (1.0), b=0x38, sub=0 → y=0x40 (2.0), overflow=0; out_valid 5 cycles after accept (one right-shift NORM cycle).
- a=0x38, b=0x38, sub=1 → y=0x00 (+0), underflow=0, exact-zero path, 3 cycles. Repeat with a=0xB8, b=0x38, sub=0 → also +0.
- a=0x38, b=0x36 (0.875), sub=1 → y=0x20 (0.125). Requires 3 left-shift NORM cycles; out_valid 7 cycles after accept.
- Rounding ties:
  - a=0x38, b=0x18 (0.0625) → y=0x38 (tie, lsb 0, round down).
  - a=0x39 (1.125), b=0x18 → y=0x3A (tie, lsb 1, round up).
  - a=0x3C (1.5), b=0x28 (0.25) → y=0x3E, exact.
- Sign and saturation:
  - a=0x28, b=0xB8 → y=0xB4 (−0.75); the larger magnitude sets the sign.
  - a=0x7F, b=0x7F → y=0x7F, overflow=1.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE → y and out_valid stable; in_ready=0; a new in_valid is ignored.
  - Assert reset during NORM → out_valid=0 and in_ready=1 immediately; no result emitted.
